// File: rtl/alu_req_arbiter_if.sv
// Request/response bundle between the requesters, the arbiter and the response consumer.
// The master side is the requester/consumer environment; the slave side is the arbiter.
interface alu_req_arbiter_if #(
    parameter int NREQ = 2,
    parameter int ID_W = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [4*NREQ-1:0] req_a;
    logic [4*NREQ-1:0] req_b;
    logic [3*NREQ-1:0] req_op;
    logic              resp_valid;
    logic              resp_ready;
    logic [ID_W-1:0]   resp_id;
    logic [7:0]        resp_data;
    logic              resp_dz;

    modport master (
        output req_valid, req_a, req_b, req_op, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_data, resp_dz
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, resp_ready,
        output req_ready, resp_valid, resp_id, resp_data, resp_dz
    );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter that shares one combinational 4-bit ALU between NREQ requesters.
//   state | meaning
//   IDLE  | waiting for a request; grants the round-robin winner
//   EXEC  | registered operands on the ALU; result captured at the end of the cycle
//   RESP  | response held on the response channel until resp_ready
module alu_req_arbiter #(
    parameter int NREQ = 2,
    parameter int ID_W = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_req_arbiter_if.slave    bus,
    output logic [3:0]          alu_a,
    output logic [3:0]          alu_b,
    output logic [2:0]          alu_sel,
    input  logic [7:0]          alu_result,
    output logic                busy,
    output logic [7:0]          op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] win_idx;
    logic            win_found;
    logic            grant;
    int              cand;

    // Search starts one past the last grant so every requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = int'(last_grant) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (!win_found && i == cand && bus.req_valid[i]) begin
                    win_found = 1'b1;
                    win_idx   = ID_W'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        bus.req_ready  = '0;
        bus.resp_valid = 1'b0;
        busy           = 1'b1;
        grant          = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (win_found) begin
                    grant                  = 1'b1;
                    bus.req_ready[win_idx] = 1'b1;
                    state_nxt              = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ALU drives stay put outside of a grant so the ALU input does not toggle needlessly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a         <= '0;
            alu_b         <= '0;
            alu_sel       <= '0;
            bus.resp_id   <= '0;
            bus.resp_data <= '0;
            bus.resp_dz   <= 1'b0;
            op_count      <= '0;
            last_grant    <= ID_W'(NREQ - 1);
        end else begin
            if (grant) begin
                alu_a       <= bus.req_a[4*int'(win_idx) +: 4];
                alu_b       <= bus.req_b[4*int'(win_idx) +: 4];
                alu_sel     <= bus.req_op[3*int'(win_idx) +: 3];
                bus.resp_id <= win_idx;
                last_grant  <= win_idx;
            end
            if (state == EXEC) begin
                bus.resp_data <= alu_result;
                bus.resp_dz   <= (alu_sel == 3'b111) && (alu_b == 4'd0);
            end
            if (state == RESP && bus.resp_ready) op_count <= op_count + 8'd1;
        end
    end

endmodule
